video_mode_ctrl: RTL and testbench
==================================

VIDEO_MODE_CTRL -- requirements
Module: video_mode_ctrl

Interface
REQ-001 SHALL have parameter STABLE_FRAMES, default 2: consecutive equal in-range frame line counts needed to lock (legal 1..7).
REQ-002 SHALL have parameter BLANK_FRAMES, default 2: frame ends with blank held across any sd_en change (legal 1..7).
REQ-003 SHALL have parameter SD_MAX_LINES, default 400: a locked count below this selects doubling.
REQ-004 SHALL have port clk_sys  input  1  single system clock; all state on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ce_pix  input  1  pixel clock enable; hs_in/vs_in sampled only when high.
REQ-007 SHALL have port hs_in  input  1  source hsync, active-high.
REQ-008 SHALL have port vs_in  input  1  source vsync, active-high.
REQ-009 SHALL have port sd_disable  input  1  user request to bypass doubling.
REQ-010 SHALL have port sd_en  output  1  selects scandoubled video path.
REQ-011 SHALL have port blank  output  1  forces video black downstream.
REQ-012 SHALL have port mode_valid  output  1  timing locked.
REQ-013 SHALL have port mode_chg  output  1  one-clk_sys pulse when sd_en is updated.
REQ-014 SHALL have port lines  output  10  locked lines per frame.
REQ-015 SHALL have port hlen  output  12  ce_pix cycles per line.

Function
REQ-016 Line edge SHALL be hs_in 1->0 and frame end SHALL be vs_in 0->1, each against the value registered on the previous ce_pix.
REQ-017 Line counter SHALL increment per line edge, saturate at 1023, and clear to 0 on frame end; a line edge coincident with frame end SHALL NOT be counted.
REQ-018 A frame count SHALL be in range when 200 <= count <= 1000.
REQ-019 FSM states SHALL be SEARCH, SWITCH, RUN; SEARCH after reset.
REQ-020 In SEARCH, blank=1 and mode_valid=0; each frame end SHALL set match to 1 if in range and unequal to previous count, increment it if equal, and clear it if out of range.
REQ-021 When match reaches STABLE_FRAMES, the FSM SHALL latch lines, compute target = (lines < SD_MAX_LINES) && !sd_disable, clear the frame counter, and enter SWITCH.
REQ-022 In SWITCH, blank=1; on the BLANK_FRAMES-th frame end, sd_en SHALL load target, mode_chg SHALL pulse, blank SHALL clear, mode_valid SHALL set, and the FSM SHALL enter RUN.
REQ-023 In RUN, a frame end with count != lines or out of range SHALL enter SEARCH, with mode_valid=0 and blank=1 on the next clk_sys; sd_en SHALL hold.
REQ-024 In RUN, if target recomputed from sd_disable != sd_en, the FSM SHALL enter SWITCH with mode_valid held at 1.
REQ-025 In SWITCH, a frame count mismatch SHALL return to SEARCH; it has priority over the REQ-022 completion.
REQ-026 Line counter saturation in RUN or SWITCH SHALL enter SEARCH with lines unchanged.
REQ-027 All outputs SHALL update one clk_sys after the ce_pix cycle that carries the causing edge.

Reset
REQ-028 While reset is high: sd_en=0, blank=1, mode_valid=0, mode_chg=0, lines=0, hlen=0, counters=0, state=SEARCH, regardless of clock.
REQ-029 Deassertion mid-frame SHALL treat the first frame end as the end of a partial frame; it is subject to REQ-020 like any other frame.

Configuration
REQ-030 With VMC_HLEN_MEASURE_EN defined, hlen SHALL load the ce_pix count between consecutive line edges (saturating at 4095) on every line edge.
REQ-031 Without VMC_HLEN_MEASURE_EN, hlen SHALL be constant 0 and no horizontal counter SHALL be synthesized.

Verification
REQ-032 Repeated 262-line frames, sd_disable=0 -> by the 5th frame end: lines=262, sd_en=1, blank=0, mode_valid=1, exactly one mode_chg pulse.
REQ-033 Repeated 525-line frames -> lines=525, sd_en=0, mode_valid=1, blank=0, one mode_chg pulse.
REQ-034 Locked at 262, inject one 263-line frame -> mode_valid=0 and blank=1 one clk_sys after that frame end; relock at 263 after 2 more 263-line frames and 2 blank frames.
REQ-035 Locked at 262, sd_disable 0->1 -> blank=1 for 2 frame ends, then sd_en=0 with a mode_chg pulse; mode_valid stays 1 throughout.
REQ-036 Locked, vs_in held low for 1100 lines -> SEARCH at line 1023; lines still 262. Separately, reset asserted during SWITCH -> all REQ-028 values on the same cycle.
REQ-037 With VMC_HLEN_MEASURE_EN defined, 858 ce_pix per line -> hlen=858; with the macro undefined -> hlen=0.

Source files
------------

// File: rtl/video_mode_if.sv
// video_mode_if: source timing inputs and mode-control outputs of video_mode_ctrl
interface video_mode_if;
  logic        ce_pix;
  logic        hs_in;
  logic        vs_in;
  logic        sd_disable;
  logic        sd_en;
  logic        blank;
  logic        mode_valid;
  logic        mode_chg;
  logic [9:0]  lines;
  logic [11:0] hlen;
  modport master (
    output ce_pix, hs_in, vs_in, sd_disable,
    input  sd_en, blank, mode_valid, mode_chg, lines, hlen
  );
  modport slave (
    input  ce_pix, hs_in, vs_in, sd_disable,
    output sd_en, blank, mode_valid, mode_chg, lines, hlen
  );
endinterface

// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: locks onto the source line count and selects the scandoubled or bypass path.
// Define VMC_HLEN_MEASURE_EN to measure ce_pix cycles per line on hlen; otherwise hlen is tied to 0.
module video_mode_ctrl #(
  parameter int STABLE_FRAMES = 2,
  parameter int BLANK_FRAMES  = 2,
  parameter int SD_MAX_LINES  = 400
) (
  input logic         clk_sys,
  input logic         reset,
  video_mode_if.slave bus
);
  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] SWITCH = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [2:0] STABLE = 3'(STABLE_FRAMES);
  localparam logic [2:0] BLANKS = 3'(BLANK_FRAMES);
  localparam logic [9:0] SD_MAX = 10'(SD_MAX_LINES);
  logic [1:0] state;
  logic       hs_q, vs_q, tgt, sd_en_q, blank_q, valid_q, chg_q;
  logic [9:0] cnt, prev, lines_q;
  logic [2:0] match, fcnt, match_nxt, fcnt_nxt;
  logic       line_edge, frame_end, in_range, go_search, tgt_run;
  assign line_edge = bus.ce_pix & hs_q & ~bus.hs_in;
  assign frame_end = bus.ce_pix & ~vs_q & bus.vs_in;
  assign in_range  = (cnt >= 10'd200) && (cnt <= 10'd1000);
  assign match_nxt = !in_range ? 3'd0 : (cnt == prev) ? match + 3'd1 : 3'd1;
  assign fcnt_nxt  = fcnt + 3'd1;
  assign tgt_run   = (lines_q < SD_MAX) & ~bus.sd_disable;
  // lock is lost when a frame disagrees with the locked count or the line counter is about to saturate
  assign go_search = (state != SEARCH) &&
                     ((frame_end && (cnt != lines_q || !in_range)) ||
                      (line_edge && !frame_end && cnt >= 10'd1022));
  // previous sync levels, updated only on pixel enable
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else if (bus.ce_pix) begin
      hs_q <= bus.hs_in;
      vs_q <= bus.vs_in;
    end
  // saturating line counter; a frame end discards a coincident line edge
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      cnt  <= 10'd0;
      prev <= 10'd0;
    end else if (frame_end) begin
      cnt  <= 10'd0;
      prev <= cnt;
    end else if (line_edge && cnt != 10'd1023) begin
      cnt <= cnt + 10'd1;
    end
  // mode FSM: search for stable timing, blank while switching, then run
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state   <= SEARCH;
      match   <= 3'd0;
      fcnt    <= 3'd0;
      tgt     <= 1'b0;
      lines_q <= 10'd0;
      sd_en_q <= 1'b0;
      blank_q <= 1'b1;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      chg_q <= 1'b0;
      if (go_search) begin
        state   <= SEARCH;
        match   <= 3'd0;
        blank_q <= 1'b1;
        valid_q <= 1'b0;
      end else if (state == SEARCH) begin
        if (frame_end) begin
          match <= match_nxt;
          if (match_nxt == STABLE) begin
            lines_q <= cnt;
            tgt     <= (cnt < SD_MAX) & ~bus.sd_disable;
            match   <= 3'd0;
            fcnt    <= 3'd0;
            state   <= SWITCH;
          end
        end
      end else if (state == SWITCH) begin
        if (frame_end) begin
          fcnt <= fcnt_nxt;
          if (fcnt_nxt == BLANKS) begin
            sd_en_q <= tgt;
            chg_q   <= 1'b1;
            blank_q <= 1'b0;
            valid_q <= 1'b1;
            state   <= RUN;
          end
        end
      end else if (state == RUN && tgt_run != sd_en_q) begin
        tgt     <= tgt_run;
        fcnt    <= 3'd0;
        blank_q <= 1'b1;
        state   <= SWITCH;
      end
    end
`ifdef VMC_HLEN_MEASURE_EN
  logic [11:0] hcnt, hcnt_inc, hlen_q;
  assign hcnt_inc = (hcnt == 12'hfff) ? hcnt : hcnt + 12'd1;
  // pixel count between consecutive line edges, saturating
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      hcnt   <= 12'd0;
      hlen_q <= 12'd0;
    end else if (line_edge) begin
      hlen_q <= hcnt_inc;
      hcnt   <= 12'd0;
    end else if (bus.ce_pix) begin
      hcnt <= hcnt_inc;
    end
  assign bus.hlen = hlen_q;
`else
  assign bus.hlen = 12'd0;
`endif
  assign bus.sd_en      = sd_en_q;
  assign bus.blank      = blank_q;
  assign bus.mode_valid = valid_q;
  assign bus.mode_chg   = chg_q;
  assign bus.lines      = lines_q;
endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb_video_mode_ctrl: random-paced sync stimulus checked every cycle against a frame-history model
module tb_video_mode_ctrl;
  localparam int STABLE = 2;
  localparam int BLANKS = 2;
  localparam int SDMAX  = 400;
  localparam int SRCH = 0, SWCH = 1, RUNM = 2;
  bit clk_sys = 1'b0;
  bit reset = 1'b1;
  video_mode_if vif();
  video_mode_ctrl #(.STABLE_FRAMES(STABLE), .BLANK_FRAMES(BLANKS), .SD_MAX_LINES(SDMAX)) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .bus(vif)
  );
  always #5 clk_sys = ~clk_sys;

  int vectors = 0, errs = 0, chg_seen = 0, hpix = 3;
  int m_mode = SRCH, m_cnt = 0, m_lines = 0, m_nb = 0, m_hc = 0, e_hlen = 0;
  bit m_hs = 1'b0, m_vs = 1'b0, m_tgt = 1'b0;
  bit e_sd = 1'b0, e_blank = 1'b1, e_valid = 1'b0, e_chg = 1'b0;
  int hist[$];

  // reference: frame counts kept as a history; lock needs a trailing run of equal in-range counts
  always @(posedge clk_sys or posedge reset) begin : model
    bit le, fe, ok, gs;
    int c, run;
    if (reset) begin
      m_mode = SRCH; m_cnt = 0; m_lines = 0; m_nb = 0; m_hc = 0; e_hlen = 0;
      m_hs = 0; m_vs = 0; m_tgt = 0; e_sd = 0; e_blank = 1; e_valid = 0; e_chg = 0;
      hist.delete();
    end else begin
      le = vif.ce_pix && m_hs && !vif.hs_in;
      fe = vif.ce_pix && !m_vs && vif.vs_in;
      if (vif.ce_pix) begin
        m_hs = vif.hs_in;
        m_vs = vif.vs_in;
      end
`ifdef VMC_HLEN_MEASURE_EN
      if (le) begin
        e_hlen = (m_hc + 1 > 4095) ? 4095 : m_hc + 1;
        m_hc = 0;
      end else if (vif.ce_pix) m_hc = (m_hc + 1 > 4095) ? 4095 : m_hc + 1;
`endif
      c = m_cnt;
      ok = c >= 200 && c <= 1000;
      if (fe) m_cnt = 0;
      else if (le && m_cnt < 1023) m_cnt++;
      e_chg = 0;
      gs = m_mode != SRCH && (fe ? (c != m_lines || !ok) : (le && m_cnt == 1023));
      if (gs) begin
        m_mode = SRCH; e_blank = 1; e_valid = 0;
        hist.delete();
      end else if (m_mode == SRCH) begin
        if (fe) begin
          hist.push_back(c);
          if (hist.size() > 8) void'(hist.pop_front());
          run = 0;
          for (int i = hist.size() - 1; i >= 0 && hist[i] == c; i--) run++;
          if (ok && run >= STABLE) begin
            m_lines = c;
            m_tgt = c < SDMAX && !vif.sd_disable;
            m_nb = 0;
            m_mode = SWCH;
          end
        end
      end else if (m_mode == SWCH) begin
        if (fe) m_nb++;
        if (m_nb == BLANKS) begin
          e_sd = m_tgt; e_chg = 1; e_blank = 0; e_valid = 1; m_mode = RUNM;
        end
      end else if ((m_lines < SDMAX && !vif.sd_disable) != e_sd) begin
        m_tgt = !e_sd; m_nb = 0; e_blank = 1; m_mode = SWCH;
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errs++;
      if (errs <= 40) $display("FAIL %s at %0t: dut=%0d expected=%0d", nm, $time, got, exp);
    end
  endtask

  task automatic pix(input bit h, input bit v);
    while ($urandom_range(3) == 0) begin
      vif.ce_pix = 1'b0;
      vif.hs_in = 1'($urandom);
      vif.vs_in = 1'($urandom);
      @(posedge clk_sys); #1;
    end
    vif.ce_pix = 1'b1;
    vif.hs_in = h;
    vif.vs_in = v;
    @(posedge clk_sys); #1;
    vif.ce_pix = 1'b0;
  endtask

  task automatic frame(input int n, input bit skip);
    for (int l = 0; l < n; l++)
      for (int p = 0; p < hpix; p++)
        if (!(skip && l == 0 && p == 0)) pix(p == 0, l < 2);
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n;
    int vals[6];
    vals = '{199, 200, 262, 263, 450, 300};
    vif.ce_pix = 1'b0; vif.hs_in = 1'b0; vif.vs_in = 1'b0; vif.sd_disable = 1'b0;
    fork
      forever begin
        @(negedge clk_sys);
        chk("sd_en", vif.sd_en, e_sd);
        chk("blank", vif.blank, e_blank);
        chk("mode_valid", vif.mode_valid, e_valid);
        chk("mode_chg", vif.mode_chg, e_chg);
        chk("lines", vif.lines, m_lines);
        chk("hlen", vif.hlen, e_hlen);
        if (vif.mode_chg) chg_seen++;
      end
    join_none
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_blank", vif.blank, 1);
    chk("rst_valid", vif.mode_valid, 0);
    chk("rst_lines", vif.lines, 0);
    chk("rst_sd_en", vif.sd_en, 0);
    reset = 1'b0;
    c0 = chg_seen;
    repeat (5) frame(262, 0);
    @(negedge clk_sys); #1;
    chk("lock262_lines", vif.lines, 262);
    chk("lock262_sd_en", vif.sd_en, 1);
    chk("lock262_blank", vif.blank, 0);
    chk("lock262_valid", vif.mode_valid, 1);
    chk("lock262_chg_count", chg_seen - c0, 1);
    frame(263, 0);
    pix(1, 1);
    chk("inject_valid", vif.mode_valid, 0);
    chk("inject_blank", vif.blank, 1);
    chk("inject_lines", vif.lines, 262);
    chk("inject_sd_en", vif.sd_en, 1);
    frame(263, 1);
    repeat (3) frame(263, 0);
    pix(1, 1);
    chk("relock_lines", vif.lines, 263);
    chk("relock_valid", vif.mode_valid, 1);
    chk("relock_blank", vif.blank, 0);
    frame(263, 1);
    vif.sd_disable = 1'b1;
    @(posedge clk_sys); #1;
    chk("disable_blank", vif.blank, 1);
    chk("disable_valid", vif.mode_valid, 1);
    chk("disable_sd_en_hold", vif.sd_en, 1);
    pix(1, 1);
    frame(263, 1);
    pix(1, 1);
    chk("disable_chg", vif.mode_chg, 1);
    chk("disable_sd_en", vif.sd_en, 0);
    chk("disable_blank_done", vif.blank, 0);
    chk("disable_valid_done", vif.mode_valid, 1);
    frame(263, 1);
    vif.sd_disable = 1'b0;
    @(posedge clk_sys); #1;
    repeat (2) frame(263, 0);
    chk("reenable_sd_en", vif.sd_en, 1);
    frame(1100, 0);
    chk("sat_valid", vif.mode_valid, 0);
    chk("sat_blank", vif.blank, 1);
    chk("sat_lines", vif.lines, 263);
    c0 = chg_seen;
    repeat (4) frame(525, 0);
    pix(1, 1);
    chk("lock525_lines", vif.lines, 525);
    chk("lock525_sd_en", vif.sd_en, 0);
    chk("lock525_blank", vif.blank, 0);
    chk("lock525_valid", vif.mode_valid, 1);
    @(negedge clk_sys); #1;
    chk("lock525_chg_count", chg_seen - c0, 1);
    frame(525, 1);
    repeat (5) frame(263, 0);
    pix(1, 1);
    chk("prereset_sd_en", vif.sd_en, 1);
    chk("prereset_lines", vif.lines, 263);
    vif.sd_disable = 1'b1;
    @(posedge clk_sys); #1;
    chk("switch_blank", vif.blank, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_sd_en", vif.sd_en, 0);
    chk("async_rst_blank", vif.blank, 1);
    chk("async_rst_valid", vif.mode_valid, 0);
    chk("async_rst_chg", vif.mode_chg, 0);
    chk("async_rst_lines", vif.lines, 0);
    chk("async_rst_hlen", vif.hlen, 0);
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    vif.sd_disable = 1'b0;
    repeat (5) begin
      n = vals[$urandom_range(5)];
      repeat ($urandom_range(3, 1)) begin
        if ($urandom_range(2) == 0) vif.sd_disable = 1'($urandom);
        frame(n, 0);
      end
    end
`ifdef VMC_HLEN_MEASURE_EN
    repeat (3) for (int p = 0; p < 858; p++) pix(p == 0, 1'b0);
    chk("hlen_858", vif.hlen, 858);
`else
    chk("hlen_off", vif.hlen, 0);
`endif
    repeat (3) @(posedge clk_sys);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
